spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- SPI slave endpoint: the receiving end of the SPI link whose SCLK is produced by the 100 MHz → 66.67 kHz divider on the master side.
- Oversamples SCLK, CS_N and MOSI in the 100 MHz system domain and deserialises MSB-first frames.
- Presents each received word with a one-cycle valid strobe to the servo steering logic.
- Shifts a response word out on MISO in the same frame. Fixed SPI mode 0 (CPOL=0, CPHA=0).

Parameters:
- DATA_W, 16: frame length in bits; also the width of rx_data and tx_data.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser; minimum 2.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: synchronous, active-high reset.
- sclk_in, input, 1: SPI clock from the master; asynchronous to clk.
- cs_n_in, input, 1: SPI chip select, active low; asynchronous.
- mosi_in, input, 1: master-out data; asynchronous.
- miso_out, output, 1: slave-out data. Driven 0 when not selected; no tri-state.
- tx_data, input, DATA_W: response word, captured at frame start.
- rx_data, output, DATA_W: last complete received word; held until the next complete frame.
- rx_valid, output, 1: one-cycle pulse when rx_data updates.
- frame_err, output, 1: one-cycle pulse when CS_N deasserts on a bad bit count.
- busy, output, 1: high while in state SHIFT.

Behaviour:
- Reset: rst is synchronous and active-high on clk. All outputs go to 0 (miso_out, rx_data, rx_valid, frame_err, busy); bit_cnt goes to 0; state goes to WAIT_IDLE.
- Synchroniser reset levels: sclk stages 0, cs_n stages 1, mosi stages 0.
- Edge detect: a rise or fall is the synchroniser output XORed with its registered previous value. Pulses last one clk cycle.
- Bandwidth requirement: SCLK high time and low time must each be ≥ 4 clk cycles, i.e. f_SCLK ≤ clk/8. The 66.67 kHz link meets this with large margin.
- FSM states: WAIT_IDLE, IDLE, SHIFT, OVERRUN.
  - WAIT_IDLE: stay here until the synchronised cs_n is 1, then go to IDLE. This prevents a spurious frame when rst is released while CS is already low.
  - IDLE: on a cs_n fall, load tx_shift <= tx_data, drive miso_out <= tx_data[DATA_W-1], clear bit_cnt, go to SHIFT.
  - SHIFT, sclk rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt <= bit_cnt+1.
  - SHIFT, when bit_cnt reaches DATA_W: in the same cycle rx_data <= the completed shift value; rx_valid is high the next cycle. Go to OVERRUN.
  - SHIFT, sclk fall with bit_cnt < DATA_W: shift tx_shift left and drive miso_out with the new MSB.
  - OVERRUN: further sclk edges are ignored and miso_out is held at 0. Any extra sclk rise sets a sticky extra_bits flag.
  - cs_n rise in SHIFT (bit_cnt ≠ DATA_W): pulse frame_err, do not touch rx_data, go to IDLE.
  - cs_n rise in OVERRUN: pulse frame_err if extra_bits is set, clear extra_bits, go to IDLE.
- MISO after deselect: miso_out returns to 0 the cycle after the cs_n rise is detected.
- Latency: rx_valid is high in the cycle after clk edge SYNC_STAGES+1, counted from the first clk edge that samples sclk_in high on the final bit.
- Simultaneous events: if a cs_n rise and an sclk rise are detected in the same cycle, the cs_n rise wins and the sclk edge is discarded.
- Reset mid-frame: the partial frame is discarded with no rx_valid and no frame_err. The FSM returns via WAIT_IDLE.
- Counter width: bit_cnt is $clog2(DATA_W+1) bits and never wraps.
- tx_data changes during a frame have no effect; it is sampled only at the IDLE→SHIFT transition.

Decomposition:
- Package spi_pkg: state enum typedef (WAIT_IDLE, IDLE, SHIFT, OVERRUN), localparam SPI_DATA_W_DEFAULT = 16.
- Sub-module sync_edge (parameters SYNC_STAGES, RESET_VAL):
  - function: SYNC_STAGES-deep synchroniser plus previous-value register;
  - outputs: level, rise, fall.
  - instantiated for sclk_in and cs_n_in.
- mosi_in uses sync_edge with its edge outputs unused.

Test Plan:
- Normal frame: CS low, 16 mode-0 bits of 0xA5C3 at 66.67 kHz, tx_data=0x1234 → rx_data=0xA5C3; exactly one rx_valid pulse; MISO bit sequence equals 0x1234 MSB-first; no frame_err; busy high during the frame only.
- Short frame: CS low, 9 SCLK pulses, CS high → frame_err pulses once; rx_valid stays 0; rx_data keeps its previous value (0xA5C3).
- Long frame: 18 SCLK pulses carrying 0x0F0F then 2 extra bits → rx_valid once with rx_data=0x0F0F; frame_err pulses at CS rise; miso_out=0 after bit 16.
- Reset with CS held low: rst asserted mid-frame at bit 5 and released with cs_n still 0, then 16 clocks sent → no rx_valid; after a CS high→low cycle, a 0x8001 frame is received correctly.
- Back-to-back frames: CS high for 10 clk cycles between frames 0xFFFF and 0x0000 → two rx_valid pulses with the correct values; tx_data changed mid-frame is not reflected on MISO until the next frame.
- Latency check: last sclk_in rise aligned to a clk edge → rx_valid high exactly in cycle SYNC_STAGES+1 after that edge (cycle 3 with default parameters).

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and defaults for the SPI slave receiver
package spi_pkg;
  localparam int SPI_DATA_W_DEFAULT = 16;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, OVERRUN} state_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-stage synchroniser with one-cycle rise/fall pulses
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = (level_o ^ prev_q) & level_o;
  assign fall_o  = (level_o ^ prev_q) & ~level_o;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled mode-0 SPI slave, MSB-first receive with MISO response
module spi_slave_rx import spi_pkg::*; #(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic              mosi_in,
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso_out,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  logic sclk_rise, sclk_fall, cs_lvl, cs_rise, cs_fall, mosi_lvl;
  state_e state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, miso_q, miso_d, extra_q, extra_d;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d_i(sclk_in), .level_o(), .rise_o(sclk_rise), .fall_o(sclk_fall));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d_i(cs_n_in), .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d_i(mosi_in), .level_o(mosi_lvl), .rise_o(), .fall_o());

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      extra_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      extra_q     <= extra_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;
    extra_d     = extra_q;
    case (state_q)
      WAIT_IDLE: begin
        // bit_cnt doubles as a settle counter so the synchroniser's reset-high cs_n is flushed first
        bit_cnt_d = cs_lvl ? bit_cnt_q + 1'b1 : '0;
        if (cs_lvl && bit_cnt_q == CNT_W'(SYNC_STAGES)) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      IDLE: if (cs_fall) begin
        tx_shift_d = tx_data;
        miso_d     = tx_data[DATA_W-1];
        bit_cnt_d  = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_lvl};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            miso_d     = 1'b0;
            state_d    = OVERRUN;
          end
        end else if (sclk_fall && bit_cnt_q < CNT_W'(DATA_W)) begin
          tx_shift_d = tx_shift_q << 1;
          miso_d     = tx_shift_q[DATA_W-2];
        end
      end
      OVERRUN: begin
        if (cs_rise) begin
          frame_err_d = extra_q;
          extra_d     = 1'b0;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sclk_rise) extra_d = 1'b1;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign miso_out  = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = state_q == SHIFT;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: scoreboard bench driving mode-0 SPI frames into spi_slave_rx
module tb_spi_slave_rx;
  localparam int SS = 2;
  logic clk = 0, rst = 1, sclk = 0, cs_n = 1, mosi = 0;
  logic [15:0] tx_data = '0;
  logic miso_out, rx_valid, frame_err, busy;
  logic [15:0] rx_data;
  int n_chk = 0, n_fail = 0, cyc = 0, rise_cyc = 0, rv_cnt = 0, fe_cnt = 0, r0, f0;
  logic [15:0] exp_q[$];
  logic [15:0] miso_cap;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk), .cs_n_in(cs_n), .mosi_in(mosi),
    .tx_data(tx_data), .miso_out(miso_out), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (!rst) begin
    if (frame_err) fe_cnt++;
    if (rx_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) chk("rx_unexpected", exp_q.size(), 1);
      else begin
        chk("rx_data", rx_data, exp_q.pop_front());
        chk("latency", cyc - rise_cyc, SS + 1);
      end
    end
  end

  task automatic cs_low(input int half);
    cs_n = 0;
    repeat (half) @(negedge clk);
  endtask

  task automatic cs_high(input int half, input int gap);
    repeat (half) @(negedge clk);
    cs_n = 1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int first, input int last, input int half);
    for (int i = first; i < last; i++) begin
      mosi = i < 16 ? w[4'(15 - i)] : 1'b1;
      repeat (half) @(negedge clk);
      if (i < 16) miso_cap[4'(15 - i)] = miso_out;
      else chk("miso_overrun", miso_out, 0);
      sclk = 1;
      if (i == 15) rise_cyc = cyc;
      repeat (half) @(negedge clk);
      sclk = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miso", miso_out, 0);
    rst = 0;
    repeat (8) @(negedge clk);
    // normal frame at the real link rate (half period 750 clk cycles)
    r0 = rv_cnt; f0 = fe_cnt;
    tx_data = 16'h1234;
    exp_q.push_back(16'hA5C3);
    cs_low(750);
    send_bits(16'hA5C3, 0, 8, 750);
    chk("busy_mid", busy, 1);
    send_bits(16'hA5C3, 8, 16, 750);
    cs_high(750, 10);
    chk("normal_miso", miso_cap, 16'h1234);
    chk("normal_valid_cnt", rv_cnt - r0, 1);
    chk("normal_err_cnt", fe_cnt - f0, 0);
    chk("normal_busy_after", busy, 0);
    chk("normal_miso_after", miso_out, 0);
    // short frame
    r0 = rv_cnt; f0 = fe_cnt;
    cs_low(8);
    send_bits(16'h0000, 0, 9, 8);
    cs_high(8, 10);
    chk("short_err_cnt", fe_cnt - f0, 1);
    chk("short_valid_cnt", rv_cnt - r0, 0);
    chk("short_rx_hold", rx_data, 16'hA5C3);
    // long frame
    r0 = rv_cnt; f0 = fe_cnt;
    exp_q.push_back(16'h0F0F);
    cs_low(8);
    send_bits(16'h0F0F, 0, 18, 8);
    cs_high(8, 10);
    chk("long_valid_cnt", rv_cnt - r0, 1);
    chk("long_err_cnt", fe_cnt - f0, 1);
    chk("long_rx", rx_data, 16'h0F0F);
    // reset mid-frame with cs_n held low
    r0 = rv_cnt; f0 = fe_cnt;
    cs_low(8);
    send_bits(16'h5555, 0, 5, 8);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    send_bits(16'hFFFF, 0, 16, 8);
    chk("rst_low_busy", busy, 0);
    cs_high(8, 10);
    chk("rst_low_valid_cnt", rv_cnt - r0, 0);
    chk("rst_low_err_cnt", fe_cnt - f0, 0);
    r0 = rv_cnt; f0 = fe_cnt;
    exp_q.push_back(16'h8001);
    cs_low(8);
    send_bits(16'h8001, 0, 16, 8);
    cs_high(8, 10);
    chk("after_rst_valid_cnt", rv_cnt - r0, 1);
    chk("after_rst_err_cnt", fe_cnt - f0, 0);
    // back-to-back frames with tx_data changed mid-frame
    r0 = rv_cnt;
    tx_data = 16'hF00D;
    exp_q.push_back(16'hFFFF);
    cs_low(8);
    send_bits(16'hFFFF, 0, 8, 8);
    tx_data = 16'h1111;
    send_bits(16'hFFFF, 8, 16, 8);
    cs_high(8, 10);
    chk("b2b_miso0", miso_cap, 16'hF00D);
    exp_q.push_back(16'h0000);
    cs_low(8);
    send_bits(16'h0000, 0, 16, 8);
    cs_high(8, 10);
    chk("b2b_miso1", miso_cap, 16'h1111);
    chk("b2b_valid_cnt", rv_cnt - r0, 2);
    repeat (20) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
